// File: rtl/led_ctrl_pkg.sv
// Lamp codes, phase encoding and per-approach lamp decode shared by the
// intersection phase arbiter and its round-robin helper.
package led_ctrl_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    typedef enum logic [1:0] {
        ALL_RED,
        GREEN,
        YELLOW,
        WALK
    } phase_e;

    // Registered control flags of the phase sequencer.
    typedef struct packed {
        phase_e state;
        logic   ped_pending;
        logic   last_was_walk;
        logic   emerg_phase;
    } ctrl_t;

    // Lamp shown by one approach given the current phase and whether it holds the grant.
    function automatic logic [2:0] lamp_code(input phase_e ph, input logic sel);
        logic [2:0] code;
        code = LAMP_RED;
        if (sel && ph == GREEN)  code = LAMP_GREEN;
        if (sel && ph == YELLOW) code = LAMP_YELLOW;
        return code;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr,
// wrapping modulo N. Returns a one-hot grant and its index (grant is 0 when idle).
module rr_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] sel;

    // Positions above ptr win first; only if none request do we wrap to the bottom.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i > int'(ptr));
        end
        sel = (|(req & hi_mask)) ? (req & hi_mask) : req;
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                gnt = '0;
                gnt[i] = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Round-robin green arbiter for N car approaches plus a pedestrian walk phase.
// Optional emergency preemption is compiled in with `define EMERGENCY_PREEMPT_EN.
module intersection_phase_arbiter
    import led_ctrl_pkg::*;
#(
    parameter int N_APPROACH  = 4,
    parameter int MIN_GREEN   = 6,
    parameter int MAX_GREEN   = 20,
    parameter int YELLOW_CYC  = 3,
    parameter int ALL_RED_CYC = 2,
    parameter int WALK_CYC    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_APPROACH-1:0]         car_req,
    input  logic                          ped_button,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                          emerg_req,
    input  logic [$clog2(N_APPROACH)-1:0] emerg_idx,
`endif
    output logic [3*N_APPROACH-1:0]       lights,
    output logic                          walk,
    output logic [$clog2(N_APPROACH)-1:0] grant_idx,
    output logic                          busy
);

    localparam int IW = $clog2(N_APPROACH);
    localparam int TW = $clog2(MAX_GREEN + 1);
    localparam logic [N_APPROACH-1:0] LSB = {{(N_APPROACH-1){1'b0}}, 1'b1};

    ctrl_t                 ctrl;
    logic [TW-1:0]         timer;
    logic [IW-1:0]         g;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         rr_idx;
    logic [N_APPROACH-1:0] rr_gnt;
    logic                  em_req;
    logic [IW-1:0]         em_idx;
    logic                  ped_any;
    logic                  others;
    logic                  rr_any;
    logic                  em_steal;
    logic                  em_hold;

`ifdef EMERGENCY_PREEMPT_EN
    assign em_req = emerg_req;
    assign em_idx = emerg_idx;
`else
    assign em_req = 1'b0;
    assign em_idx = '0;
`endif

    // A button press on the decision cycle itself must count.
    assign ped_any  = ctrl.ped_pending | ped_button;
    assign others   = |(car_req & ~(LSB << g));
    assign rr_any   = |rr_gnt;
    assign em_steal = em_req && (em_idx != g);
    assign em_hold  = em_req && (em_idx == g);

    rr_arbiter #(
        .N  (N_APPROACH),
        .IW (IW)
    ) u_rr (
        .req (car_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl.state         <= ALL_RED;
            ctrl.ped_pending   <= 1'b0;
            ctrl.last_was_walk <= 1'b0;
            ctrl.emerg_phase   <= 1'b0;
            timer              <= '0;
            g                  <= '0;
            rr_ptr             <= IW'(N_APPROACH - 1);
        end else begin
            ctrl.ped_pending <= ped_any;
            timer            <= timer + TW'(1);
            case (ctrl.state)
                ALL_RED: begin
                    // Timer parks at the clearance threshold so an idle crossing re-decides every cycle.
                    if (timer >= TW'(ALL_RED_CYC - 1)) begin
                        timer <= timer;
                        if (em_req) begin
                            ctrl.state       <= GREEN;
                            ctrl.emerg_phase <= 1'b1;
                            g                <= em_idx;
                            timer            <= '0;
                        end else if (ped_any && !ctrl.last_was_walk) begin
                            ctrl.state       <= WALK;
                            ctrl.ped_pending <= 1'b0;
                            timer            <= '0;
                        end else if (rr_any) begin
                            ctrl.state       <= GREEN;
                            ctrl.emerg_phase <= 1'b0;
                            g                <= rr_idx;
                            timer            <= '0;
                        end else if (ped_any) begin
                            ctrl.state       <= WALK;
                            ctrl.ped_pending <= 1'b0;
                            timer            <= '0;
                        end
                    end
                end
                GREEN: begin
                    if (em_steal) begin
                        ctrl.state <= YELLOW;
                        timer      <= '0;
                    end else if (em_hold) begin
                        // Held indefinitely; saturating here forces yellow as soon as the hold drops.
                        if (timer >= TW'(MAX_GREEN - 1)) timer <= timer;
                    end else if (timer >= TW'(MAX_GREEN - 1)) begin
                        ctrl.state <= YELLOW;
                        timer      <= '0;
                    end else if (timer >= TW'(MIN_GREEN - 1) &&
                                 (!car_req[g] || others || ctrl.ped_pending)) begin
                        ctrl.state <= YELLOW;
                        timer      <= '0;
                    end
                end
                YELLOW: begin
                    if (timer >= TW'(YELLOW_CYC - 1)) begin
                        ctrl.state         <= ALL_RED;
                        ctrl.last_was_walk <= 1'b0;
                        timer              <= '0;
                        if (!ctrl.emerg_phase) rr_ptr <= g;
                    end
                end
                WALK: begin
                    if (em_req) begin
                        ctrl.state       <= ALL_RED;
                        ctrl.ped_pending <= 1'b1;
                        timer            <= '0;
                    end else if (timer >= TW'(WALK_CYC - 1)) begin
                        ctrl.state         <= ALL_RED;
                        ctrl.last_was_walk <= 1'b1;
                        timer              <= '0;
                    end
                end
                default: begin
                    ctrl.state <= ALL_RED;
                    timer      <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_APPROACH; i++) begin : g_lamp
        assign lights[3*i +: 3] = lamp_code(ctrl.state, g == IW'(i));
    end

    assign walk      = (ctrl.state == WALK);
    assign busy      = (ctrl.state != ALL_RED);
    assign grant_idx = g;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench for intersection_phase_arbiter: phase-level reference model checked
// every cycle, plus hand-computed phase lengths and grant orders.
module tb_intersection_phase_arbiter;

    localparam int NA = 4;
    localparam int MIN_GREEN = 6, MAX_GREEN = 20, YELLOW_CYC = 3, ALL_RED_CYC = 2, WALK_CYC = 8;
    localparam int P_RED = 0, P_GRN = 1, P_YEL = 2, P_WLK = 3;
`ifdef EMERGENCY_PREEMPT_EN
    localparam bit EMERG = 1'b1;
`else
    localparam bit EMERG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NA-1:0]   car_req;
    logic            ped_button;
    logic            emerg_req;
    logic [1:0]      emerg_idx;
    logic [3*NA-1:0] lights;
    logic            walk;
    logic [1:0]      grant_idx;
    logic            busy;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    intersection_phase_arbiter #(
        .N_APPROACH(NA), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .YELLOW_CYC(YELLOW_CYC), .ALL_RED_CYC(ALL_RED_CYC), .WALK_CYC(WALK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car_req    (car_req),
        .ped_button (ped_button),
`ifdef EMERGENCY_PREEMPT_EN
        .emerg_req  (emerg_req),
        .emerg_idx  (emerg_idx),
`endif
        .lights     (lights),
        .walk       (walk),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    // Phase-level model: which phase, how long we have been in it, who was served last.
    typedef struct packed {
        int ph;
        int age;
        int g;
        int last;
        bit ped;
        bit lw;
        bit em;
    } ms_t;

    ms_t m;

    function automatic ms_t model_reset();
        ms_t s;
        s.ph = P_RED; s.age = 0; s.g = 0; s.last = NA - 1;
        s.ped = 1'b0; s.lw = 1'b0; s.em = 1'b0;
        return s;
    endfunction

    function automatic ms_t model_next(ms_t s, logic [NA-1:0] req, logic pb, logic er, int ei);
        ms_t n;
        bit others;
        bit found;
        n = s;
        n.ped = s.ped | pb;
        n.age = s.age + 1;
        others = 1'b0;
        for (int k = 0; k < NA; k++) if (k != s.g && req[k]) others = 1'b1;
        case (s.ph)
            P_RED: if (s.age >= ALL_RED_CYC - 1) begin
                if (EMERG && er) begin
                    n.ph = P_GRN; n.g = ei; n.em = 1'b1; n.age = 0;
                end else if (n.ped && !s.lw) begin
                    n.ph = P_WLK; n.ped = 1'b0; n.age = 0;
                end else if (req != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= NA; k++) begin
                        if (!found && req[(s.last + k) % NA]) begin
                            found = 1'b1; n.g = (s.last + k) % NA;
                        end
                    end
                    n.ph = P_GRN; n.em = 1'b0; n.age = 0;
                end else if (n.ped) begin
                    n.ph = P_WLK; n.ped = 1'b0; n.age = 0;
                end
            end
            P_GRN: begin
                if (EMERG && er && ei != s.g) begin
                    n.ph = P_YEL; n.age = 0;
                end else if (EMERG && er) begin
                    n.ph = P_GRN;
                end else if (s.age >= MAX_GREEN - 1) begin
                    n.ph = P_YEL; n.age = 0;
                end else if (s.age >= MIN_GREEN - 1 && (!req[s.g] || others || s.ped)) begin
                    n.ph = P_YEL; n.age = 0;
                end
            end
            P_YEL: if (s.age >= YELLOW_CYC - 1) begin
                n.ph = P_RED; n.age = 0; n.lw = 1'b0;
                if (!s.em) n.last = s.g;
            end
            default: begin
                if (EMERG && er) begin
                    n.ph = P_RED; n.age = 0; n.ped = 1'b1;
                end else if (s.age >= WALK_CYC - 1) begin
                    n.ph = P_RED; n.age = 0; n.lw = 1'b1;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [3*NA-1:0] exp_lights(ms_t s);
        logic [3*NA-1:0] r;
        for (int i = 0; i < NA; i++) begin
            if (s.g == i && s.ph == P_GRN)      r[3*i +: 3] = 3'b100;
            else if (s.g == i && s.ph == P_YEL) r[3*i +: 3] = 3'b010;
            else                                r[3*i +: 3] = 3'b001;
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_next(m, car_req, ped_button, emerg_req, int'(emerg_idx));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("lights", lights, exp_lights(m));
            chk("walk", walk, m.ph == P_WLK);
            chk("grant_idx", grant_idx, m.g);
            chk("busy", busy, m.ph != P_RED);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] obs(int idx);
        if (idx < 0) return {2'b00, walk};
        return lights[3*idx +: 3];
    endfunction

    function automatic int green_idx();
        int r;
        r = -1;
        for (int i = 0; i < NA; i++) if (lights[3*i +: 3] == 3'b100) r = i;
        return r;
    endfunction

    // Count consecutive observations (including the current one) showing code on idx.
    task automatic dur(input int idx, input logic [2:0] code, output int n);
        n = 0;
        while (obs(idx) == code && n < 64) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_obs(input int idx, input logic [2:0] code, input int budget, output int n);
        n = 0;
        while (obs(idx) != code && n < budget) begin
            n++;
            step(1);
        end
    endtask

    task automatic wait_green(input int budget, output int n, output int gi);
        n = 0;
        while (green_idx() < 0 && n < budget) begin
            n++;
            step(1);
        end
        gi = green_idx();
    endtask

    initial begin
        int n, n2, gi;
        int order[4];
        order = '{1, 2, 3, 0};
        reset = 1'b1; car_req = '0; ped_button = 1'b0; emerg_req = 1'b0; emerg_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_lights", lights, 12'h249);
        chk("rst_walk", walk, 1'b0);
        chk("rst_grant", grant_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);

        // Single held requester: full max green, yellow, clearance, re-grant.
        car_req = 4'b0001; reset = 1'b0;
        wait_green(10, n, gi);
        chk("first_grant_lat", n, 2);
        chk("first_grant_idx", gi, 0);
        dur(0, 3'b100, n); chk("max_green_len", n, 20);
        dur(0, 3'b010, n); chk("yellow_len", n, 3);
        dur(0, 3'b001, n); chk("all_red_len", n, 2);
        chk("regrant_idx", green_idx(), 0);

        // All approaches requesting: min-green round robin.
        car_req = 4'b1111;
        dur(0, 3'b100, n); chk("rr_green_len0", n, 6);
        for (int k = 0; k < 4; k++) begin
            wait_green(10, n, gi);
            chk("rr_order", gi, order[k]);
            if (k < 3) begin
                dur(gi, 3'b100, n2); chk("rr_green_len", n2, 6);
            end
        end

        // Reset in the middle of a green: lamps drop immediately.
        step(1);
        car_req = 4'b0010; reset = 1'b1;
        #1;
        chk("midrst_lights", lights, 12'h249);
        chk("midrst_walk", walk, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        step(2);
        reset = 1'b0;
        wait_green(10, n, gi);
        chk("postrst_lat", n, 2);
        chk("postrst_idx", gi, 1);

        // Pedestrian press at green timer 2 cuts the green at min length.
        step(2);
        ped_button = 1'b1; step(1); ped_button = 1'b0;
        dur(1, 3'b100, n); chk("ped_cut_green", n + 3, 6);
        car_req = 4'b0100;
        dur(1, 3'b010, n); chk("ped_yellow", n, 3);
        wait_obs(-1, 3'b001, 10, n); chk("walk_lat", n, 2);
        step(2);
        ped_button = 1'b1; step(1); ped_button = 1'b0;
        dur(-1, 3'b001, n); chk("walk_len", n + 3, 8);

        // Second press during walk must not starve the waiting car.
        wait_green(10, n, gi);
        chk("after_walk_lat", n, 2);
        chk("after_walk_idx", gi, 2);
        dur(2, 3'b100, n); chk("ped_pend_green", n, 6);
        dur(2, 3'b010, n); chk("ped_pend_yellow", n, 3);
        wait_obs(-1, 3'b001, 10, n); chk("walk2_lat", n, 2);
        car_req = '0;
        dur(-1, 3'b001, n); chk("walk2_len", n, 8);
        step(4);
        chk("idle_busy", busy, 1'b0);
        chk("idle_lights", lights, 12'h249);

        // Press on an idle decision cycle counts immediately.
        ped_button = 1'b1; step(1); ped_button = 1'b0;
        chk("idle_ped_walk", walk, 1'b1);
        dur(-1, 3'b001, n); chk("walk3_len", n, 8);

        // Car and press together right after a walk: car goes first.
        step(3);
        car_req = 4'b1000; ped_button = 1'b1; step(1); ped_button = 1'b0;
        chk("car_after_walk", green_idx(), 3);
        dur(3, 3'b100, n); chk("car_after_walk_len", n, 6);
        car_req = '0;
        dur(3, 3'b010, n); chk("yellow3_len", n, 3);
        wait_obs(-1, 3'b001, 10, n); chk("walk4_lat", n, 2);
        dur(-1, 3'b001, n); chk("walk4_len", n, 8);

`ifdef EMERGENCY_PREEMPT_EN
        // Emergency on approach 3 during approach 0 green.
        car_req = 4'b0001;
        wait_green(10, n, gi);
        chk("em_pre_idx", gi, 0);
        step(1);
        emerg_req = 1'b1; emerg_idx = 2'd3;
        step(1);
        chk("em_cut_yellow", obs(0), 3'b010);
        dur(0, 3'b010, n); chk("em_yellow_len", n, 3);
        wait_green(10, n, gi);
        chk("em_grant_lat", n, 2);
        chk("em_grant_idx", gi, 3);
        step(25);
        chk("em_hold", obs(3), 3'b100);
        emerg_req = 1'b0;
        step(1);
        chk("em_release", obs(3), 3'b010);
        step(12);
        car_req = '0;
`endif

        step(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
